// File: rtl/sqw_pkg.sv
// rtl/sqw_pkg.sv - shared state, config types and default limits for the square-wave generator
package sqw_pkg;

   localparam int SQW_COUNTER_WIDTH = 18;
   localparam int SQW_MIN_PERIOD    = 2000;
   localparam int SQW_MAX_PERIOD    = 200000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } sqw_state_t;

   typedef struct packed {
      logic [SQW_COUNTER_WIDTH-1:0] period;
      logic [SQW_COUNTER_WIDTH-1:0] high;
   } sqw_cfg_t;

   // A missing or impossible high time falls back to a 50 % duty cycle.
   function automatic logic [SQW_COUNTER_WIDTH-1:0] sqw_clamp_high(
      input logic [SQW_COUNTER_WIDTH-1:0] period,
      input logic [SQW_COUNTER_WIDTH-1:0] high
   );
      return ((high == '0) || (high >= period)) ? (period >> 1) : high;
   endfunction

endpackage

// File: rtl/sqw_cfg_buffer.sv
// rtl/sqw_cfg_buffer.sv - config handshake, validation, duty clamp and single-entry shadow register
module sqw_cfg_buffer
   import sqw_pkg::*;
#(
   parameter int MIN_PERIOD = SQW_MIN_PERIOD,
   parameter int MAX_PERIOD = SQW_MAX_PERIOD
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [SQW_COUNTER_WIDTH-1:0] cfg_period,
   input  logic [SQW_COUNTER_WIDTH-1:0] cfg_high,
   output logic                         cfg_err,
   input  logic                         apply,
   output logic                         shadow_pending,
   output sqw_cfg_t                     shadow
);

   localparam logic [SQW_COUNTER_WIDTH-1:0] MIN_P = SQW_COUNTER_WIDTH'(MIN_PERIOD);
   localparam logic [SQW_COUNTER_WIDTH-1:0] MAX_P = SQW_COUNTER_WIDTH'(MAX_PERIOD);

   logic xfer;
   logic legal;

   assign cfg_ready = ~shadow_pending;
   assign xfer      = cfg_valid && cfg_ready;
   assign legal     = (cfg_period >= MIN_P) && (cfg_period <= MAX_P);

   // Illegal configs still complete the handshake; they are only reported and dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_pending <= 1'b0;
         shadow         <= '0;
         cfg_err        <= 1'b0;
      end else begin
         cfg_err <= xfer && !legal;
         if (xfer && legal) begin
            shadow_pending <= 1'b1;
            shadow.period  <= cfg_period;
            shadow.high    <= sqw_clamp_high(cfg_period, cfg_high);
         end else if (apply) begin
            shadow_pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/square_wave_gen.sv
// rtl/square_wave_gen.sv - programmable square-wave generator: FSM, period counter, registered outputs
// Optional burst mode (burst_len/burst_done) is built when SQW_BURST_EN is defined.
module square_wave_gen
   import sqw_pkg::*;
#(
   parameter int COUNTER_WIDTH = SQW_COUNTER_WIDTH,
   parameter int MIN_PERIOD    = SQW_MIN_PERIOD,
   parameter int MAX_PERIOD    = SQW_MAX_PERIOD
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [COUNTER_WIDTH-1:0] cfg_period,
   input  logic [COUNTER_WIDTH-1:0] cfg_high,
   output logic                     cfg_err,
   output logic                     wave_out,
   output logic                     period_start,
`ifdef SQW_BURST_EN
   input  logic [15:0]              burst_len,
   output logic                     burst_done,
`endif
   output logic                     active
);

   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

   sqw_state_t               state_q;
   sqw_state_t               state_d;
   logic [COUNTER_WIDTH-1:0] cnt_q;
   logic [COUNTER_WIDTH-1:0] cnt_d;
   logic [COUNTER_WIDTH-1:0] period_last;
   logic [COUNTER_WIDTH-1:0] high_last;
   sqw_cfg_t                 act_q;
   sqw_cfg_t                 shadow;
   logic                     loaded_q;
   logic                     shadow_pending;
   logic                     apply;
   logic                     boundary;
   logic                     wave_d;
   logic                     start_d;
   logic                     run_ok;
   logic                     burst_stop;

   sqw_cfg_buffer #(
      .MIN_PERIOD (MIN_PERIOD),
      .MAX_PERIOD (MAX_PERIOD)
   ) u_cfg (
      .clk            (clk),
      .rst_n          (rst_n),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .cfg_period     (SQW_COUNTER_WIDTH'(cfg_period)),
      .cfg_high       (SQW_COUNTER_WIDTH'(cfg_high)),
      .cfg_err        (cfg_err),
      .apply          (apply),
      .shadow_pending (shadow_pending),
      .shadow         (shadow)
   );

   assign period_last = COUNTER_WIDTH'(act_q.period) - CNT_ONE;
   assign high_last   = COUNTER_WIDTH'(act_q.high) - CNT_ONE;
   assign boundary    = (state_q == LOW) && (cnt_q == period_last);

   // While idle no waveform is in flight, so the shadow can be taken at once.
   assign apply = shadow_pending && (!loaded_q || (state_q == IDLE) || boundary);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q    <= '0;
         loaded_q <= 1'b0;
      end else if (apply) begin
         act_q    <= shadow;
         loaded_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         wave_out     <= 1'b0;
         period_start <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wave_out     <= wave_d;
         period_start <= start_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (enable && loaded_q && run_ok) begin
               state_d = HIGH;
            end
         end
         HIGH: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == high_last) begin
               state_d = LOW;
            end
         end
         LOW: begin
            if (boundary) begin
               cnt_d   = '0;
               state_d = (enable && !burst_stop) ? HIGH : IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      wave_d  = (state_d == HIGH);
      start_d = (state_d == HIGH) && (state_q != HIGH);
   end

   assign active = (state_q != IDLE);

`ifdef SQW_BURST_EN
   logic [15:0] burst_rem_q;
   logic        burst_hold_q;

   assign run_ok     = !burst_hold_q;
   assign burst_stop = (burst_rem_q == 16'd1);

   // burst_hold_q blocks a restart until enable has been seen low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_rem_q  <= '0;
         burst_hold_q <= 1'b0;
         burst_done   <= 1'b0;
      end else begin
         burst_done <= boundary && burst_stop;
         if ((state_q == IDLE) && (state_d == HIGH)) begin
            burst_rem_q <= burst_len;
         end else if (boundary && (burst_rem_q != 16'd0)) begin
            burst_rem_q <= burst_rem_q - 16'd1;
         end
         if (boundary && burst_stop) begin
            burst_hold_q <= 1'b1;
         end else if (!enable) begin
            burst_hold_q <= 1'b0;
         end
      end
   end
`else
   assign run_ok     = 1'b1;
   assign burst_stop = 1'b0;
`endif

endmodule

// File: tb/tb_square_wave_gen.sv
// tb/tb_square_wave_gen.sv - randomized scoreboard bench for square_wave_gen
module tb_square_wave_gen;

   localparam int CW      = 18;
   localparam int MIN_P   = 2000;
   localparam int MAX_P   = 200000;
   localparam int LIMIT   = 5000;

   typedef struct {
      int period;
      int high;
   } per_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_period;
   logic [CW-1:0] cfg_high;
   logic          cfg_err;
   logic          wave_out;
   logic          period_start;
   logic          active;

   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_starts = 0;
   per_t pend_q[$];
   int   err_q[$];

   square_wave_gen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_period   (cfg_period),
      .cfg_high     (cfg_high),
      .cfg_err      (cfg_err),
      .wave_out     (wave_out),
      .period_start (period_start),
      .active       (active)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   task automatic timed_out(input string name, input int lim);
      n_checks++;
      $display("FAIL %s: no event within %0d cycles, expected one", name, lim);
   endtask

   task automatic wait_start(input string name, input int lim, output int c);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_start && n < lim);
      if (!period_start) timed_out(name, lim);
      c = cyc;
   endtask

   // Reference rule: legal configs are queued with the duty clamp applied,
   // illegal ones expect a cfg_err pulse on the cycle after the transfer.
   task automatic send_cfg(input int p, input int h, output int xc);
      int n = 0;
      cfg_valid  = 1'b1;
      cfg_period = p[CW-1:0];
      cfg_high   = h[CW-1:0];
      while (!cfg_ready && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (!cfg_ready) timed_out("cfg_handshake", LIMIT);
      if (p < MIN_P || p > MAX_P) err_q.push_back(cyc + 1);
      @(negedge clk);
      cfg_valid = 1'b0;
      xc = cyc;
      if (p >= MIN_P && p <= MAX_P)
         pend_q.push_back('{period: p, high: ((h == 0 || h >= p) ? p / 2 : h)});
   endtask

   // Monitor: measures each period and pops the config the model says it must use.
   initial begin : monitor
      per_t cur_exp;
      per_t act_cfg;
      bit   act_ok    = 1'b0;
      bit   in_per    = 1'b0;
      bit   prev_wave = 1'b0;
      bit   prev_act  = 1'b0;
      int   cur_start = 0;
      int   cur_high  = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_per    = 1'b0;
            act_ok    = 1'b0;
            prev_wave = 1'b0;
            prev_act  = 1'b0;
            pend_q.delete();
            err_q.delete();
         end else begin
            if (cfg_err) begin
               if (err_q.size() == 0) check("cfg_err_expected", 0, 1);
               else check("cfg_err_cycle", cyc, err_q.pop_front());
            end
            if (wave_out && !prev_wave) check("start_at_rise", period_start, 1);
            if (period_start) begin
               check("rise_at_start", wave_out && !prev_wave, 1);
               if (in_per) begin
                  check("period_len", cyc - cur_start, cur_exp.period);
                  check("high_len", cur_high, cur_exp.high);
               end
               if (pend_q.size() > 0) begin
                  act_cfg = pend_q.pop_front();
                  act_ok  = 1'b1;
               end
               check("start_has_cfg", act_ok, 1);
               cur_exp   = act_cfg;
               cur_start = cyc;
               cur_high  = 0;
               in_per    = 1'b1;
               n_starts++;
            end else if (in_per && prev_act && !active) begin
               check("last_period_len", cyc - cur_start, cur_exp.period);
               check("last_high_len", cur_high, cur_exp.high);
               in_per = 1'b0;
            end
            if (in_per && wave_out) cur_high++;
            prev_wave = wave_out;
            prev_act  = active;
         end
      end
   end

   initial begin : watchdog
      #(10 * 120000);
      $display("FAIL watchdog: simulation still running after 120000 cycles, expected end");
      n_checks++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : stimulus
      int xc, sc, sc2, t0, s0, n, n_hi, k, p, h, mode;
      rst_n      = 1'b0;
      enable     = 1'b0;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      cfg_high   = '0;
      repeat (3) @(negedge clk);
      check("rst_wave", wave_out, 0);
      check("rst_start", period_start, 0);
      check("rst_active", active, 0);
      check("rst_err", cfg_err, 0);
      check("rst_ready", cfg_ready, 1);
      rst_n = 1'b1;
      enable = 1'b1;
      repeat (5) @(negedge clk);
      check("enable_without_cfg", active, 0);

      send_cfg(2000, 500, xc);
      wait_start("first_start", 10, sc);
      check("first_rise_latency", sc - xc, 2);
      repeat (3) wait_start("steady_start", LIMIT, sc);

      k = $urandom_range(10, 1500);
      repeat (k) @(negedge clk);
      send_cfg(100, 50, xc);
      check("illegal_keeps_ready", cfg_ready, 1);
      wait_start("after_illegal", LIMIT, sc);

      k = $urandom_range(10, 1900);
      repeat (k) @(negedge clk);
      send_cfg(4000, 0, xc);
      check("ready_low_pending", cfg_ready, 0);
      n = 0;
      n_hi = 0;
      do begin
         @(negedge clk);
         n++;
         if (!period_start && cfg_ready) n_hi++;
      end while (!period_start && n < LIMIT);
      if (!period_start) timed_out("boundary_after_4000", LIMIT);
      check("ready_low_until_boundary", n_hi, 0);
      check("ready_high_at_boundary", cfg_ready, 1);

      for (int i = 0; i < 6; i++) begin
         wait_start("rand_start", LIMIT, sc);
         k = $urandom_range(5, 1500);
         repeat (k) @(negedge clk);
         if (i == 1) send_cfg(MIN_P - 1, 10, xc);
         if (i == 3) send_cfg($urandom_range(MAX_P + 1, 262143), 0, xc);
         p    = (i == 0) ? MIN_P : $urandom_range(2000, 3000);
         mode = $urandom_range(0, 3);
         case (mode)
            0:       h = 0;
            1:       h = p + $urandom_range(0, 100);
            2:       h = p - 1;
            default: h = $urandom_range(1, p - 1);
         endcase
         send_cfg(p, h, xc);
      end
      wait_start("rand_last", LIMIT, sc);
      k = $urandom_range(5, 1500);
      repeat (k) @(negedge clk);
      send_cfg(2000, 1000, xc);
      wait_start("fixed_start", LIMIT, sc);

      repeat (10) @(negedge clk);
      enable = 1'b0;
      s0 = n_starts;
      n = 0;
      while (active && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (active) timed_out("drop_to_idle", LIMIT);
      check("drop_full_period", cyc - sc, 2000);
      check("drop_wave_low", wave_out, 0);
      repeat (100) @(negedge clk);
      check("no_start_while_off", n_starts - s0, 0);
      check("idle_inactive", active, 0);
      enable = 1'b1;
      t0 = cyc;
      wait_start("restart", 10, sc);
      check("restart_latency", sc - t0, 1);

      repeat (10) @(negedge clk);
      enable = 1'b0;
      repeat (500) @(negedge clk);
      enable = 1'b1;
      wait_start("no_gap_start", LIMIT, sc2);
      check("no_gap_spacing", sc2 - sc, 2000);

      repeat (5) @(negedge clk);
      send_cfg(MAX_P, 0, xc);
      check("max_period_accepted", cfg_ready, 0);
      repeat (20) @(negedge clk);
      check("pre_reset_high", wave_out, 1);
      s0 = n_starts;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_wave", wave_out, 0);
      check("async_rst_ready", cfg_ready, 1);
      check("async_rst_active", active, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      check("no_restart_after_rst", active, 0);
      check("no_start_after_rst", n_starts - s0, 0);
      check("err_queue_drained", err_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/square_wave_gen.md
Name: square_wave_gen

Overview:
- Programmable square-wave generator; the transmit-side counterpart of the period-measuring frequency detector.
- Produces a registered square wave whose period and high time are given in clk cycles.
- Configuration arrives over a valid/ready handshake and takes effect glitch-free at the next period boundary.
- Used as a self-test stimulus source and as a 1 kHz–100 kHz output at clk = 200 MHz.

Parameters:
- COUNTER_WIDTH, 18, width of period/high counters (200 MHz / 1 kHz = 200_000 < 2^18).
- MIN_PERIOD, 2000, smallest legal period in clk cycles (100 kHz); must be >= 2.
- MAX_PERIOD, 200000, largest legal period in clk cycles (1 kHz); must be < 2^COUNTER_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- enable  in  1  level: run generator.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  shadow register empty; a config can be accepted.
- cfg_period  in  COUNTER_WIDTH  period in clk cycles.
- cfg_high  in  COUNTER_WIDTH  high time in clk cycles.
- cfg_err  out  1  one-cycle pulse: last accepted config was illegal and was dropped.
- wave_out  out  1  registered square-wave output.
- period_start  out  1  one-cycle pulse on the first cycle of each period (wave_out rising).
- active  out  1  generator is in HIGH or LOW state.

Behaviour:
- Interface decision: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - wave_out=0, period_start=0, active=0, cfg_err=0, cfg_ready=1.
  - Shadow empty; active config invalid (cfg_loaded=0); counter=0; state IDLE.
- Handshake: transfer occurs on a cycle with cfg_valid && cfg_ready. cfg_ready = ~shadow_pending. Data must be held stable while cfg_valid=1 && cfg_ready=0.
- Validation, at the transfer cycle:
  - If cfg_period < MIN_PERIOD or > MAX_PERIOD: the transfer completes, the data is dropped, and cfg_err pulses on the next cycle. Shadow and active config are unchanged.
  - Else if cfg_high==0 or cfg_high >= cfg_period: high is stored as cfg_period>>1 (floor). Not an error.
  - Else both values are stored as given. shadow_pending=1.
- Application:
  - If the active config is invalid, the shadow moves to active on the cycle after the transfer, regardless of state.
  - Otherwise the shadow moves only on a boundary cycle (counter == period-1).
  - shadow_pending clears on the move, so cfg_ready rises one cycle later.
  - A transfer on a boundary cycle is not applied at that boundary.
- State machine:
  - IDLE → HIGH when enable && cfg_loaded. Next cycle: wave_out=1, counter=0, period_start=1.
  - HIGH: wave_out=1. When counter==high-1 → LOW.
  - LOW: wave_out=0. When counter==period-1 (boundary):
    - if enable → HIGH with counter=0 and period_start=1, using the freshly applied config if the shadow was pending;
    - else → IDLE.
  - enable deasserted mid-period: the current period completes in full (no runt pulse), then IDLE.
  - enable reasserted before the boundary: no gap between periods.
- Outputs: active=1 in HIGH/LOW. wave_out is a direct register output with no combinational path.
- Rising-edge-to-rising-edge spacing is exactly the active period, so the frequency detector reports it as its period.
- Counter: unsigned COUNTER_WIDTH, resets to 0 at each boundary, never wraps (period <= MAX_PERIOD).
- Asynchronous reset mid-operation: all state returns to reset values immediately; the config is lost.

Optional Feature:
- Macro: SQW_BURST_EN.
- With the macro defined:
  - Adds input burst_len [15:0] and output burst_done (1).
  - burst_len==0 means continuous running.
  - Otherwise burst_len is sampled on the IDLE→HIGH transition. Exactly burst_len periods are emitted, then the block returns to IDLE even if enable is still high.
  - burst_done pulses for one cycle on the IDLE entry cycle.
  - A new burst requires enable to go low then high again.
- Without the macro: ports are absent and running is continuous while enabled.

Decomposition:
- Package sqw_pkg:
  - state enum {IDLE, HIGH, LOW};
  - default MIN_PERIOD/MAX_PERIOD constants;
  - cfg struct {period, high}.
- One sub-module, sqw_cfg_buffer: handshake, validation, duty clamp, cfg_err and shadow register. It exposes shadow_pending, shadow cfg and an apply strobe input.
- The main module holds the FSM, counter and outputs.

Test Plan:
- Reset, then config period=2000/high=500, enable=1 → first wave_out rise 2 cycles after the transfer; rises every 2000 cycles; high exactly 500 cycles; period_start coincident with each rise.
- Config period=100 (< MIN) → cfg_err pulses once 1 cycle after the transfer; waveform unchanged; cfg_ready stays 1.
- Running at 2000 cycles, send period=4000/high=0 mid-period:
  - cfg_ready goes low until the boundary;
  - the current period finishes at 2000;
  - the next period is 4000 with a 2000 high.
- enable dropped 10 cycles into a period of 2000 → the period completes (high time untouched), then wave_out=0 and active=0; no period_start until enable returns.
- Assert rst_n low mid-HIGH → wave_out=0 and cfg_ready=1 immediately; enable alone does not restart (no config loaded).
- With SQW_BURST_EN, burst_len=3, period=2000 → exactly 3 rises; burst_done 6000 cycles after the first rise; stays IDLE while enable is held high.
